// File: rtl/chroma_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : chroma_compositor
//  Purpose  : Speckle-filters the chroma-key flag, replaces keyed pixels with
//             a background colour and counts keyed pixels per frame.
//  Revision : 1.0  initial release
// ============================================================================
module chroma_compositor #(
   parameter int PIPE_LAT = 2,
   parameter int CNT_W    = 19
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             DE,
   input  logic             h_sync,
   input  logic             v_sync,
   input  logic [11:0]      fg_rgb,
   input  logic             bg_pixel,
   input  logic [11:0]      bg_rgb,
   input  logic             comp_en,
   output logic [11:0]      rgb_out,
   output logic             de_out,
   output logic             h_sync_out,
   output logic             v_sync_out,
   output logic [CNT_W-1:0] bg_count,
   output logic             bg_count_valid
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   // Timing delay lines; bit 0 is the stage-1 copy, the top bit drives the port
   logic [PIPE_LAT-1:0] r_de_sr;
   logic [PIPE_LAT-1:0] r_hs_sr;
   logic [PIPE_LAT-1:0] r_vs_sr;

   logic [11:0]      r_fg1;
   logic [11:0]      r_bg1;
   logic             r_en1;
   logic             r_m1;
   logic             r_m_prev;
   logic             r_de_prev;
   logic [11:0]      r_rgb;
   logic [CNT_W-1:0] r_acc;
   logic [CNT_W-1:0] r_bg_count;
   logic             r_valid;

   logic             w_l;
   logic             w_r;
   logic             w_f;
   logic             w_inc;
   logic             w_vs_fall;
   logic [CNT_W-1:0] w_acc_next;

   // Neighbours outside the active line replicate the centre mask
   assign w_l = r_de_prev ? r_m_prev : r_m1;
   assign w_r = DE ? bg_pixel : r_m1;
   assign w_f = (w_l & r_m1) | (w_l & w_r) | (r_m1 & w_r);

   assign w_inc      = r_de_sr[0] & w_f;
   assign w_acc_next = (w_inc && (r_acc != c_cnt_max)) ? r_acc + c_cnt_one : r_acc;
   // v_sync_out is about to take the stage-1 value: a 1->0 step is the boundary
   assign w_vs_fall  = r_vs_sr[PIPE_LAT-1] & ~r_vs_sr[PIPE_LAT-2];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_de_sr    <= '0;
         r_hs_sr    <= '1;
         r_vs_sr    <= '1;
         r_fg1      <= '0;
         r_bg1      <= '0;
         r_en1      <= 1'b0;
         r_m1       <= 1'b0;
         r_m_prev   <= 1'b0;
         r_de_prev  <= 1'b0;
         r_rgb      <= '0;
         r_acc      <= '0;
         r_bg_count <= '0;
         r_valid    <= 1'b0;
      end else begin
         r_de_sr   <= {r_de_sr[PIPE_LAT-2:0], DE};
         r_hs_sr   <= {r_hs_sr[PIPE_LAT-2:0], h_sync};
         r_vs_sr   <= {r_vs_sr[PIPE_LAT-2:0], v_sync};
         r_fg1     <= fg_rgb;
         r_bg1     <= bg_rgb;
         r_en1     <= comp_en;
         r_m1      <= bg_pixel & DE;
         r_m_prev  <= r_m1;
         r_de_prev <= r_de_sr[0];

         if (!r_de_sr[0]) begin
            r_rgb <= '0;
         end else if (r_en1 && w_f) begin
            r_rgb <= r_bg1;
         end else begin
            r_rgb <= r_fg1;
         end

         if (w_vs_fall) begin
            r_bg_count <= w_acc_next;
            r_acc      <= '0;
            r_valid    <= 1'b1;
         end else begin
            r_acc      <= w_acc_next;
            r_valid    <= 1'b0;
         end
      end
   end

   assign rgb_out        = r_rgb;
   assign de_out         = r_de_sr[PIPE_LAT-1];
   assign h_sync_out     = r_hs_sr[PIPE_LAT-1];
   assign v_sync_out     = r_vs_sr[PIPE_LAT-1];
   assign bg_count       = r_bg_count;
   assign bg_count_valid = r_valid;

endmodule
`default_nettype wire
